camera_dvp_emulator: RTL

- Synthetic 8-bit parallel-camera source: generates PCLK, HS (line-valid), VS (frame-valid) and data, emulating the sensor end of the DVP link our luminance receiver consumes.
- Used for on-FPGA loopback and bench stimulus of the receive and depth pipeline without a physical camera.
- Pixel content comes from an internal test pattern or an upstream byte source.

---
 rtl/camera_dvp_emulator.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/camera_dvp_emulator.sv
// Synthetic DVP camera source: emulated PCLK plus HS/VS/data timing with an
// internal test-pattern generator or an upstream byte source. All video
// outputs change only on the PCLK falling edge so they are centred on the
// rising edge that the receiver samples.
module camera_dvp_emulator #(
  parameter int H_ACTIVE      = 320,
  parameter int V_ACTIVE      = 240,
  parameter int H_BLANK       = 16,
  parameter int V_BLANK_LINES = 4,
  parameter int PCLK_HALF     = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic [1:0] pattern_sel_in,
  input  logic [7:0] pixel_data_in,
  output logic       pixel_req_out,
  output logic       cam_pclk_out,
  output logic       cam_hs_out,
  output logic       cam_vs_out,
  output logic [7:0] cam_data_out,
  output logic       frame_start_out,
  output logic       busy_out
);

  localparam int LINE_TICKS = H_BLANK + H_ACTIVE;
  localparam int VB_TICKS   = V_BLANK_LINES * LINE_TICKS;
  // One blank counter serves both vertical and horizontal blanking.
  localparam int BLANK_MAX  = (VB_TICKS > H_BLANK) ? VB_TICKS : H_BLANK;
  localparam int BW = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;
  localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int PW = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;

  typedef enum logic [1:0] {IDLE, VBLANK, HBLANK, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] half_cnt_q, half_cnt_d;
  logic          pclk_q, pclk_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] line_q, line_d;
  logic [1:0]    sel_q, sel_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [7:0]    data_q, data_d;
  logic          frame_start_q, frame_start_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          load;
  logic [CW-1:0] load_col;
  logic          pixel_req;

  function automatic logic [7:0] pattern_byte(input logic [1:0]    mode,
                                               input logic [CW-1:0] col,
                                               input logic [LW-1:0] line,
                                               input logic [7:0]    ext);
    logic [7:0] c8;
    logic [7:0] l8;
    c8 = 8'(col);
    l8 = 8'(line);
    case (mode)
      2'd1:    pattern_byte = c8;
      2'd2:    pattern_byte = l8;
      2'd3:    pattern_byte = (c8[3] ^ l8[3]) ? 8'hFF : 8'h00;
      default: pattern_byte = ext;
    endcase
  endfunction

  // Next-state logic: PCLK divider, frame/line sequencer and pixel loading.
  always_comb begin
    state_d       = state_q;
    half_cnt_d    = half_cnt_q;
    pclk_d        = pclk_q;
    blank_cnt_d   = blank_cnt_q;
    col_d         = col_q;
    line_d        = line_q;
    sel_d         = sel_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    data_d        = data_q;
    frame_start_d = 1'b0;
    busy_d        = busy_q;
    load          = 1'b0;
    load_col      = '0;
    pixel_req     = 1'b0;

    if (half_cnt_q == PW'(PCLK_HALF - 1)) begin
      half_cnt_d = '0;
      pclk_d     = ~pclk_q;
    end else begin
      half_cnt_d = half_cnt_q + PW'(1);
    end

    // A tick is the cycle whose closing edge drives PCLK from 1 to 0.
    tick = (half_cnt_q == PW'(PCLK_HALF - 1)) && pclk_q;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (enable_in) begin
            state_d     = VBLANK;
            sel_d       = pattern_sel_in;
            blank_cnt_d = '0;
            busy_d      = 1'b1;
          end
        end
        VBLANK: begin
          if (blank_cnt_q == BW'(VB_TICKS - 1)) begin
            state_d       = HBLANK;
            blank_cnt_d   = '0;
            line_d        = '0;
            vs_d          = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            blank_cnt_d = blank_cnt_q + BW'(1);
          end
        end
        HBLANK: begin
          if (blank_cnt_q == BW'(H_BLANK - 1)) begin
            state_d  = ACTIVE;
            col_d    = '0;
            hs_d     = 1'b1;
            load     = 1'b1;
            load_col = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + BW'(1);
          end
        end
        default: begin
          if (col_q == CW'(H_ACTIVE - 1)) begin
            hs_d        = 1'b0;
            data_d      = 8'h00;
            blank_cnt_d = '0;
            col_d       = '0;
            if (line_q != LW'(V_ACTIVE - 1)) begin
              line_d  = line_q + LW'(1);
              state_d = HBLANK;
            end else begin
              // Frame boundary: enable and pattern select are sampled here.
              vs_d   = 1'b0;
              line_d = '0;
              if (enable_in) begin
                state_d = VBLANK;
                sel_d   = pattern_sel_in;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end
          end else begin
            col_d    = col_q + CW'(1);
            load     = 1'b1;
            load_col = col_q + CW'(1);
          end
        end
      endcase
    end

    if (load) begin
      data_d    = pattern_byte(sel_q, load_col, line_q, pixel_data_in);
      pixel_req = (sel_q == 2'd0);
    end
  end

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      half_cnt_q    <= '0;
      pclk_q        <= 1'b0;
      blank_cnt_q   <= '0;
      col_q         <= '0;
      line_q        <= '0;
      sel_q         <= 2'd0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      data_q        <= 8'h00;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      half_cnt_q    <= half_cnt_d;
      pclk_q        <= pclk_d;
      blank_cnt_q   <= blank_cnt_d;
      col_q         <= col_d;
      line_q        <= line_d;
      sel_q         <= sel_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign pixel_req_out   = pixel_req;
  assign cam_pclk_out    = pclk_q;
  assign cam_hs_out      = hs_q;
  assign cam_vs_out      = vs_q;
  assign cam_data_out    = data_q;
  assign frame_start_out = frame_start_q;
  assign busy_out        = busy_q;

endmodule
